stopwatch_bcd: RTL and testbench
================================

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter HOUR_MODULUS, default 100, meaning hours count 0..HOUR_MODULUS-1 (legal range 2..100).
REQ-002 SHALL have port clock, input, 1, single system clock (100 MHz); all state on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port time_tick, input, 1, one-cycle enable every 10 ms (hundredth of a second) from the upstream prescaler.
REQ-005 SHALL have port start_stop, input, 1, debounced, synchronous level from a button; the block acts on its rising edge.
REQ-006 SHALL have port clear, input, 1, debounced, synchronous level; the block acts on its rising edge.
REQ-007 SHALL have port lap, input, 1, debounced, synchronous level; the block acts on its rising edge.
REQ-008 SHALL have port digits, output, 32, packed BCD {H10,H1,M10,M1,S10,S1,C10,C1}; [3:0] is the least significant digit, feeding the 8-digit seven-segment display directly.
REQ-009 SHALL have port running, output, 1, high while in state RUN.
REQ-010 SHALL have port frozen, output, 1, high while the lap display is held.
REQ-011 SHALL have port overflow, output, 1, sticky flag, set on wrap past the maximum count.

Function
REQ-012 SHALL register each of start_stop/clear/lap once and generate a one-cycle edge pulse (in & ~in_q); level held high SHALL produce only one pulse.
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE.
REQ-014 Transitions SHALL be: IDLE --start_stop edge--> RUN; RUN --start_stop edge--> PAUSE; PAUSE --start_stop edge--> RUN; IDLE/PAUSE --clear edge--> IDLE.
REQ-015 A clear edge in RUN SHALL be ignored.
REQ-016 Same-cycle edge priority SHALL be clear > start_stop > lap; only the winning edge is acted upon, and lower-priority edges are discarded.
REQ-017 The count SHALL advance by one hundredth on a cycle where time_tick=1 and the current (pre-transition) state is RUN.
REQ-018 Consequently, a tick coinciding with RUN->PAUSE SHALL be counted, and a tick coinciding with IDLE->RUN or PAUSE->RUN SHALL NOT be counted.
REQ-019 Digit moduli SHALL be C1:10, C10:10, S1:10, S10:6, M1:10, M10:6.
REQ-020 Hours (H10,H1) SHALL count 0..HOUR_MODULUS-1 in BCD.
REQ-021 Carry SHALL ripple combinationally within the cycle; all eight digits update in the same clock edge (1-cycle latency from tick to digits).
REQ-022 At maximum (HOUR_MODULUS-1):59:59.99, a counted tick SHALL wrap all digits to 0 and set overflow=1 in the same cycle.
REQ-023 Overflow SHALL remain set until clear or reset.
REQ-024 Entering IDLE SHALL zero all count digits, clear overflow and clear frozen, all on the same edge.
REQ-025 A lap edge in RUN or PAUSE with frozen=0 SHALL copy the current count (post-increment value if a tick is counted that cycle) into a lap register and set frozen=1.
REQ-026 A lap edge with frozen=1 SHALL clear frozen.
REQ-027 A lap edge in IDLE SHALL be ignored.
REQ-028 digits SHALL equal the lap register when frozen=1, else the live count; counting continues while frozen.
REQ-029 No BCD digit SHALL ever hold a value above 9 (above 5 for S10/M10).

Reset
REQ-030 On reset=1, at the next clock edge: state=IDLE, all count and lap digits=0, digits=32'h0, running=0, frozen=0, overflow=0, and edge-detect registers=0.
REQ-031 Reset SHALL override every other input, including mid-count and while frozen.
REQ-032 A button held high through reset release SHALL NOT produce an edge.

Structure
REQ-033 Package stopwatch_pkg SHALL hold the state enum typedef (IDLE, RUN, PAUSE) and the digit-modulus constants.
REQ-034 Sub-module bcd_digit_counter SHALL implement one digit: parameter MODULUS; inputs clock, reset, clr, en; outputs digit[3:0], carry (en & digit==MODULUS-1).
REQ-035 The top level SHALL instantiate bcd_digit_counter for C1..M10, plus one two-digit hour stage honouring HOUR_MODULUS.

Verification
REQ-036 Reset, then start_stop edge, then 100 ticks -> digits=32'h0000_0100, running=1.
REQ-037 Preload to 00:59:59.99 via ticks, then one tick -> digits=32'h0100_0000.
REQ-038 With HOUR_MODULUS=2, at 01:59:59.99 one tick -> digits=0 and overflow=1; clear is ignored in RUN; stop then clear -> overflow=0.
REQ-039 RUN at 00:00:00.05: lap edge, then 10 ticks -> digits stays 32'h05, frozen=1; second lap -> digits=32'h15.
REQ-040 start_stop edge coinciding with a tick in RUN -> PAUSE, count incremented by 1; further ticks -> no change.
REQ-041 In PAUSE, clear and start_stop edges in the same cycle -> IDLE, digits=0, running=0; holding start_stop high for 50 cycles -> exactly one transition.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM states, digit moduli
// and a single-digit BCD step function.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 8;

    localparam int unsigned MOD_C1  = 10;
    localparam int unsigned MOD_C10 = 10;
    localparam int unsigned MOD_S1  = 10;
    localparam int unsigned MOD_S10 = 6;
    localparam int unsigned MOD_M1  = 10;
    localparam int unsigned MOD_M10 = 6;

    // Value a digit takes after this edge given its enable and modulus.
    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic en,
                                            input int unsigned modulus);
        if (!en) begin
            return d;
        end
        if (d == 4'(modulus - 1)) begin
            return 4'd0;
        end
        return d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit counting 0..MODULUS-1; carry is asserted combinationally
// on the enabled cycle in which the digit wraps.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] r_digit;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_digit <= '0;
        end else begin
            r_digit <= bcd_step(r_digit, en, MODULUS);
        end
    end

    assign digit = r_digit;
    assign carry = en & (r_digit == 4'(MODULUS - 1));

endmodule

// File: rtl/stopwatch_bcd.sv
// Hundredths-resolution BCD stopwatch with start/stop, clear, lap freeze and
// a sticky overflow flag; all eight digits update on the same edge.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int unsigned HOUR_MODULUS = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        time_tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [31:0] digits,
    output logic        running,
    output logic        frozen,
    output logic        overflow
);

    localparam logic [3:0] H_MAX_T = 4'((HOUR_MODULUS - 1) / 10);
    localparam logic [3:0] H_MAX_O = 4'((HOUR_MODULUS - 1) % 10);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_running;
    logic        r_ss_q;
    logic        r_clr_q;
    logic        r_lap_q;
    logic        r_rst_q;
    logic        r_frozen;
    logic        r_overflow;
    logic [31:0] r_lap;
    logic [3:0]  r_h10;
    logic [3:0]  r_h1;
    logic [3:0]  w_h10_next;
    logic [3:0]  w_h1_next;

    logic w_ss_edge, w_clr_edge, w_lap_edge;
    logic w_clr_act, w_ss_act, w_lap_act;
    logic w_en_c1, w_h_en, w_h_at_max, w_wrap;
    logic w_cy_c1, w_cy_c10, w_cy_s1, w_cy_s10, w_cy_m1, w_cy_m10;
    logic [3:0] w_c1, w_c10, w_s1, w_s10, w_m1, w_m10;
    logic [31:0] w_count;
    logic [31:0] w_count_next;

    // Edge detectors; r_rst_q masks the first cycle after reset so a button
    // held through reset release is not seen as a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ss_q  <= 1'b0;
            r_clr_q <= 1'b0;
            r_lap_q <= 1'b0;
            r_rst_q <= 1'b1;
        end else begin
            r_ss_q  <= start_stop;
            r_clr_q <= clear;
            r_lap_q <= lap;
            r_rst_q <= 1'b0;
        end
    end

    assign w_ss_edge  = start_stop & ~r_ss_q  & ~r_rst_q;
    assign w_clr_edge = clear      & ~r_clr_q & ~r_rst_q;
    assign w_lap_edge = lap        & ~r_lap_q & ~r_rst_q;

    // Priority clear > start_stop > lap; a clear in RUN does not count as a winner.
    assign w_clr_act = w_clr_edge & (r_state != RUN);
    assign w_ss_act  = w_ss_edge & ~w_clr_act;
    assign w_lap_act = w_lap_edge & ~w_clr_act & ~w_ss_edge & (r_state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_running <= (w_state_next == RUN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_clr_act) begin
            w_state_next = IDLE;
        end else if (w_ss_act) begin
            case (r_state)
                IDLE:    w_state_next = RUN;
                RUN:     w_state_next = PAUSE;
                PAUSE:   w_state_next = RUN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Counting uses the pre-transition state.
    assign w_en_c1 = time_tick & (r_state == RUN);

    bcd_digit_counter #(.MODULUS(MOD_C1)) u_c1 (
        .clock(clock), .reset(reset), .clr(w_clr_act), .en(w_en_c1),
        .digit(w_c1), .carry(w_cy_c1));
    bcd_digit_counter #(.MODULUS(MOD_C10)) u_c10 (
        .clock(clock), .reset(reset), .clr(w_clr_act), .en(w_cy_c1),
        .digit(w_c10), .carry(w_cy_c10));
    bcd_digit_counter #(.MODULUS(MOD_S1)) u_s1 (
        .clock(clock), .reset(reset), .clr(w_clr_act), .en(w_cy_c10),
        .digit(w_s1), .carry(w_cy_s1));
    bcd_digit_counter #(.MODULUS(MOD_S10)) u_s10 (
        .clock(clock), .reset(reset), .clr(w_clr_act), .en(w_cy_s1),
        .digit(w_s10), .carry(w_cy_s10));
    bcd_digit_counter #(.MODULUS(MOD_M1)) u_m1 (
        .clock(clock), .reset(reset), .clr(w_clr_act), .en(w_cy_s10),
        .digit(w_m1), .carry(w_cy_m1));
    bcd_digit_counter #(.MODULUS(MOD_M10)) u_m10 (
        .clock(clock), .reset(reset), .clr(w_clr_act), .en(w_cy_m1),
        .digit(w_m10), .carry(w_cy_m10));

    // Two-digit hour stage wrapping at HOUR_MODULUS-1.
    assign w_h_en     = w_cy_m10;
    assign w_h_at_max = (r_h10 == H_MAX_T) && (r_h1 == H_MAX_O);
    assign w_wrap     = w_h_en & w_h_at_max;

    always_comb begin
        w_h10_next = r_h10;
        w_h1_next  = r_h1;
        if (w_h_en) begin
            if (w_h_at_max) begin
                w_h10_next = 4'd0;
                w_h1_next  = 4'd0;
            end else if (r_h1 == 4'd9) begin
                w_h10_next = r_h10 + 4'd1;
                w_h1_next  = 4'd0;
            end else begin
                w_h1_next  = r_h1 + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_clr_act) begin
            r_h10 <= '0;
            r_h1  <= '0;
        end else begin
            r_h10 <= w_h10_next;
            r_h1  <= w_h1_next;
        end
    end

    assign w_count = {r_h10, r_h1, w_m10, w_m1, w_s10, w_s1, w_c10, w_c1};
    assign w_count_next = {w_h10_next, w_h1_next,
                           bcd_step(w_m10, w_cy_m1,  MOD_M10),
                           bcd_step(w_m1,  w_cy_s10, MOD_M1),
                           bcd_step(w_s10, w_cy_s1,  MOD_S10),
                           bcd_step(w_s1,  w_cy_c10, MOD_S1),
                           bcd_step(w_c10, w_cy_c1,  MOD_C10),
                           bcd_step(w_c1,  w_en_c1,  MOD_C1)};

    // Lap capture takes the post-increment value so a same-cycle tick is included.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_frozen   <= 1'b0;
            r_overflow <= 1'b0;
            r_lap      <= '0;
        end else if (w_clr_act) begin
            r_frozen   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wrap) begin
                r_overflow <= 1'b1;
            end
            if (w_lap_act) begin
                if (!r_frozen) begin
                    r_lap    <= w_count_next;
                    r_frozen <= 1'b1;
                end else begin
                    r_frozen <= 1'b0;
                end
            end
        end
    end

    assign digits   = r_frozen ? r_lap : w_count;
    assign running  = r_running;
    assign frozen   = r_frozen;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd: two instances share stimulus, one with
// default hours and one with HOUR_MODULUS=2 for the short-wrap case.
module tb_stopwatch_bcd;

    logic        clock;
    logic        reset;
    logic        time_tick;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [31:0] digits_a, digits_b;
    logic        running_a, running_b;
    logic        frozen_a, frozen_b;
    logic        overflow_a, overflow_b;
    logic [31:0] pl_val;

    int checks;
    int errors;

    stopwatch_bcd #(.HOUR_MODULUS(100)) dut_a (
        .clock(clock), .reset(reset), .time_tick(time_tick),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .digits(digits_a), .running(running_a), .frozen(frozen_a),
        .overflow(overflow_a));

    stopwatch_bcd #(.HOUR_MODULUS(2)) dut_b (
        .clock(clock), .reset(reset), .time_tick(time_tick),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .digits(digits_b), .running(running_b), .frozen(frozen_b),
        .overflow(overflow_b));

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic ticks(input int n);
        time_tick = 1'b1;
        repeat (n) @(negedge clock);
        time_tick = 1'b0;
    endtask

    task automatic press_ss();
        start_stop = 1'b1;
        @(negedge clock);
        start_stop = 1'b0;
        @(negedge clock);
    endtask

    task automatic press_clr();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
    endtask

    task automatic press_lap();
        lap = 1'b1;
        @(negedge clock);
        lap = 1'b0;
        @(negedge clock);
    endtask

    // Count preloads: force the digit registers briefly, then release so they hold.
    task preload_a(input logic [31:0] v);
        pl_val = v;
        force dut_a.r_h10 = pl_val[31:28];
        force dut_a.r_h1 = pl_val[27:24];
        force dut_a.u_m10.r_digit = pl_val[23:20];
        force dut_a.u_m1.r_digit = pl_val[19:16];
        force dut_a.u_s10.r_digit = pl_val[15:12];
        force dut_a.u_s1.r_digit = pl_val[11:8];
        force dut_a.u_c10.r_digit = pl_val[7:4];
        force dut_a.u_c1.r_digit = pl_val[3:0];
        #1;
        release dut_a.r_h10;
        release dut_a.r_h1;
        release dut_a.u_m10.r_digit;
        release dut_a.u_m1.r_digit;
        release dut_a.u_s10.r_digit;
        release dut_a.u_s1.r_digit;
        release dut_a.u_c10.r_digit;
        release dut_a.u_c1.r_digit;
    endtask

    task preload_b(input logic [31:0] v);
        pl_val = v;
        force dut_b.r_h10 = pl_val[31:28];
        force dut_b.r_h1 = pl_val[27:24];
        force dut_b.u_m10.r_digit = pl_val[23:20];
        force dut_b.u_m1.r_digit = pl_val[19:16];
        force dut_b.u_s10.r_digit = pl_val[15:12];
        force dut_b.u_s1.r_digit = pl_val[11:8];
        force dut_b.u_c10.r_digit = pl_val[7:4];
        force dut_b.u_c1.r_digit = pl_val[3:0];
        #1;
        release dut_b.r_h10;
        release dut_b.r_h1;
        release dut_b.u_m10.r_digit;
        release dut_b.u_m1.r_digit;
        release dut_b.u_s10.r_digit;
        release dut_b.u_s1.r_digit;
        release dut_b.u_c10.r_digit;
        release dut_b.u_c1.r_digit;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_stop = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (digits_a !== 32'h0) begin
            errors++; $display("FAIL reset_digits got %h want %h", digits_a, 32'h0);
        end
        checks++;
        if ({running_a, frozen_a, overflow_a} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want %b", {running_a, frozen_a, overflow_a}, 3'b000);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (running_a !== 1'b0) begin
            errors++; $display("FAIL held_button_release running got %b want 0", running_a);
        end
        start_stop = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_count();
        press_ss();
        ticks(1);
        checks++;
        if (digits_a !== 32'h0000_0001) begin
            errors++; $display("FAIL count_1 got %h want %h", digits_a, 32'h1);
        end
        ticks(99);
        checks++;
        if (digits_a !== 32'h0000_0100 || running_a !== 1'b1) begin
            errors++; $display("FAIL count_100 got %h/%b want %h/1", digits_a, running_a, 32'h100);
        end
        ticks(5899);
        checks++;
        if (digits_a !== 32'h0000_5999) begin
            errors++; $display("FAIL count_5999 got %h want %h", digits_a, 32'h5999);
        end
        ticks(1);
        checks++;
        if (digits_a !== 32'h0001_0000) begin
            errors++; $display("FAIL minute_carry got %h want %h", digits_a, 32'h0001_0000);
        end
    endtask

    task automatic test_pause_tick();
        start_stop = 1'b1; time_tick = 1'b1;
        @(negedge clock);
        start_stop = 1'b0; time_tick = 1'b0;
        @(negedge clock);
        checks++;
        if (digits_a !== 32'h0001_0001 || running_a !== 1'b0) begin
            errors++; $display("FAIL pause_tick got %h/%b want %h/0", digits_a, running_a, 32'h0001_0001);
        end
        ticks(5);
        checks++;
        if (digits_a !== 32'h0001_0001) begin
            errors++; $display("FAIL pause_hold got %h want %h", digits_a, 32'h0001_0001);
        end
    endtask

    task automatic test_lap();
        press_clr();
        checks++;
        if (digits_a !== 32'h0 || running_a !== 1'b0) begin
            errors++; $display("FAIL clear_pause got %h/%b want 0/0", digits_a, running_a);
        end
        start_stop = 1'b1; time_tick = 1'b1;
        @(negedge clock);
        start_stop = 1'b0; time_tick = 1'b0;
        ticks(5);
        checks++;
        if (digits_a !== 32'h05 || running_a !== 1'b1) begin
            errors++; $display("FAIL start_tick_uncounted got %h/%b want %h/1", digits_a, running_a, 32'h05);
        end
        press_lap();
        ticks(10);
        checks++;
        if (digits_a !== 32'h05 || frozen_a !== 1'b1) begin
            errors++; $display("FAIL lap_frozen got %h/%b want %h/1", digits_a, frozen_a, 32'h05);
        end
        press_lap();
        checks++;
        if (digits_a !== 32'h15 || frozen_a !== 1'b0) begin
            errors++; $display("FAIL lap_release got %h/%b want %h/0", digits_a, frozen_a, 32'h15);
        end
        lap = 1'b1; time_tick = 1'b1;
        @(negedge clock);
        lap = 1'b0; time_tick = 1'b0;
        @(negedge clock);
        ticks(3);
        checks++;
        if (digits_a !== 32'h16 || frozen_a !== 1'b1) begin
            errors++; $display("FAIL lap_post_increment got %h/%b want %h/1", digits_a, frozen_a, 32'h16);
        end
        press_lap();
        checks++;
        if (digits_a !== 32'h19) begin
            errors++; $display("FAIL lap_live_continue got %h want %h", digits_a, 32'h19);
        end
    endtask

    task automatic test_priority();
        press_clr();
        checks++;
        if (digits_a !== 32'h19 || running_a !== 1'b1) begin
            errors++; $display("FAIL clear_in_run got %h/%b want %h/1", digits_a, running_a, 32'h19);
        end
        press_ss();
        clear = 1'b1; start_stop = 1'b1;
        @(negedge clock);
        clear = 1'b0; start_stop = 1'b0;
        @(negedge clock);
        checks++;
        if (digits_a !== 32'h0 || running_a !== 1'b0) begin
            errors++; $display("FAIL clear_beats_ss got %h/%b want 0/0", digits_a, running_a);
        end
        start_stop = 1'b1;
        repeat (50) @(negedge clock);
        checks++;
        if (running_a !== 1'b1) begin
            errors++; $display("FAIL ss_hold_one_edge running got %b want 1", running_a);
        end
        start_stop = 1'b0;
        @(negedge clock);
        start_stop = 1'b1; lap = 1'b1;
        @(negedge clock);
        start_stop = 1'b0; lap = 1'b0;
        @(negedge clock);
        checks++;
        if (running_a !== 1'b0 || frozen_a !== 1'b0) begin
            errors++; $display("FAIL ss_beats_lap got %b/%b want 0/0", running_a, frozen_a);
        end
        press_clr();
        press_lap();
        checks++;
        if (frozen_a !== 1'b0) begin
            errors++; $display("FAIL lap_in_idle frozen got %b want 0", frozen_a);
        end
    endtask

    task automatic test_hours();
        press_ss();
        preload_a(32'h0059_5999);
        preload_b(32'h0059_5999);
        @(negedge clock);
        ticks(1);
        checks++;
        if (digits_a !== 32'h0100_0000 || digits_b !== 32'h0100_0000) begin
            errors++; $display("FAIL hour_carry got %h/%h want %h", digits_a, digits_b, 32'h0100_0000);
        end
        preload_a(32'h0959_5999);
        @(negedge clock);
        ticks(1);
        checks++;
        if (digits_a !== 32'h1000_0000) begin
            errors++; $display("FAIL hour_tens_carry got %h want %h", digits_a, 32'h1000_0000);
        end
        preload_a(32'h9959_5999);
        preload_b(32'h0159_5999);
        @(negedge clock);
        checks++;
        if (overflow_a !== 1'b0 || overflow_b !== 1'b0) begin
            errors++; $display("FAIL overflow_premax got %b/%b want 0/0", overflow_a, overflow_b);
        end
        ticks(1);
        checks++;
        if (digits_a !== 32'h0 || overflow_a !== 1'b1) begin
            errors++; $display("FAIL wrap_h100 got %h/%b want 0/1", digits_a, overflow_a);
        end
        checks++;
        if (digits_b !== 32'h0 || overflow_b !== 1'b1) begin
            errors++; $display("FAIL wrap_h2 got %h/%b want 0/1", digits_b, overflow_b);
        end
        ticks(3);
        press_clr();
        checks++;
        if (digits_b !== 32'h03 || overflow_b !== 1'b1 || running_b !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky got %h/%b/%b want 3/1/1", digits_b, overflow_b, running_b);
        end
        press_ss();
        press_clr();
        checks++;
        if (digits_b !== 32'h0 || overflow_b !== 1'b0 || overflow_a !== 1'b0) begin
            errors++; $display("FAIL overflow_clear got %h/%b/%b want 0/0/0", digits_b, overflow_b, overflow_a);
        end
    endtask

    task automatic test_reset_override();
        press_ss();
        ticks(3);
        press_lap();
        ticks(2);
        checks++;
        if (digits_a !== 32'h03 || frozen_a !== 1'b1) begin
            errors++; $display("FAIL pre_reset_frozen got %h/%b want 3/1", digits_a, frozen_a);
        end
        reset = 1'b1; start_stop = 1'b1; time_tick = 1'b1;
        @(negedge clock);
        checks++;
        if (digits_a !== 32'h0 || {running_a, frozen_a, overflow_a} !== 3'b000) begin
            errors++; $display("FAIL reset_override got %h/%b want 0/000", digits_a, {running_a, frozen_a, overflow_a});
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (running_a !== 1'b0 || digits_a !== 32'h0) begin
            errors++; $display("FAIL reset_release_hold got %b/%h want 0/0", running_a, digits_a);
        end
        start_stop = 1'b0; time_tick = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clock = 1'b0;
        reset = 1'b1;
        time_tick = 1'b0;
        start_stop = 1'b0;
        clear = 1'b0;
        lap = 1'b0;
        pl_val = '0;
        test_reset();
        test_count();
        test_pause_tick();
        test_lap();
        test_priority();
        test_hours();
        test_reset_override();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
